// File: rtl/m3_pkg.sv
// Shared types and constants for the dequantize / pre-IDCT block writer.
// Holds the FSM encoding, SRAM region layout and the per-frequency shift tables.
package m3_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } m3_dqw_state_type;

    localparam logic [17:0] PRE_IDCT_BASE = 18'd76800;
    localparam logic [17:0] U_SEG_OFFSET  = 18'd76800;
    localparam logic [17:0] V_SEG_OFFSET  = 18'd115200;

    localparam int Y_BLK_COLS  = 40;
    localparam int UV_BLK_COLS = 20;
    localparam int BLK_ROWS    = 30;

    // d = row + col, 0..14; higher frequencies get coarser steps.
    function automatic logic [2:0] q0_shift(input logic [3:0] d);
        logic [2:0] s;
        case (d)
            4'd0:          s = 3'd3;
            4'd1:          s = 3'd1;
            4'd2, 4'd3:    s = 3'd2;
            4'd4, 4'd5:    s = 3'd3;
            4'd6, 4'd7:    s = 3'd4;
            default:       s = 3'd5;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] q1_shift(input logic [3:0] d);
        logic [2:0] s;
        if (d == 4'd0)      s = 3'd3;
        else if (d <= 4'd3) s = 3'd0;
        else if (d <= 4'd7) s = 3'd1;
        else                s = 3'd2;
        return s;
    endfunction

    function automatic logic [2:0] shift_amt(input logic sel, input logic [3:0] d);
        return sel ? q1_shift(d) : q0_shift(d);
    endfunction

endpackage

// File: rtl/m3_zigzag_lut.sv
// Standard JPEG 8x8 zigzag: scan index -> (row, col).
// Table entries are row*8+col, so the entry bits split directly into row and col.
module m3_zigzag_lut (
    input  logic [5:0] i_zz_idx,
    output logic [2:0] o_row,
    output logic [2:0] o_col
);

    localparam logic [5:0] ZZ_POS [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [5:0] w_pos;

    assign w_pos = ZZ_POS[i_zz_idx];
    assign o_row = w_pos[5:3];
    assign o_col = w_pos[2:0];

endmodule

// File: rtl/m3_dequant_block_writer.sv
// Dequantizes zigzag-ordered coefficients and writes them, one word per cycle,
// into the Y/U/V pre-IDCT block layout in external SRAM.
module m3_dequant_block_writer
    import m3_pkg::*;
#(
    parameter int BLK_COLS_Y  = m3_pkg::Y_BLK_COLS,
    parameter int BLK_COLS_UV = m3_pkg::UV_BLK_COLS,
    parameter int BLK_ROWS_N  = m3_pkg::BLK_ROWS
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    input  logic        q_sel,
    input  logic        coef_valid,
    input  logic [15:0] coef_data,
    output logic        coef_ready,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        block_done,
    output logic        done
);

    m3_dqw_state_type r_state;

    logic        r_qsel;
    logic [5:0]  r_zz;
    logic [5:0]  r_blk_col;
    logic [4:0]  r_blk_row;
    logic [1:0]  r_seg;
    logic [17:0] r_addr;
    logic [15:0] r_data;
    logic        r_we_n;
    logic        r_block_done;
    logic        r_done;

    logic        w_xfer;
    logic [2:0]  w_row;
    logic [2:0]  w_col;
    logic [5:0]  w_cols_m1;
    logic        w_col_wrap;
    logic        w_row_wrap;
    logic        w_last_blk;

    m3_zigzag_lut u_zz (
        .i_zz_idx (r_zz),
        .o_row    (w_row),
        .o_col    (w_col)
    );

    assign coef_ready = (r_state == S_ACCEPT);
    assign w_xfer     = coef_valid && coef_ready;

    assign w_cols_m1  = (r_seg == 2'd0) ? 6'(BLK_COLS_Y - 1) : 6'(BLK_COLS_UV - 1);
    assign w_col_wrap = (r_blk_col == w_cols_m1);
    assign w_row_wrap = (r_blk_row == 5'(BLK_ROWS_N - 1));
    assign w_last_blk = (r_seg == 2'd2) && w_row_wrap && w_col_wrap;

    // Address: pixel line times segment stride, built from shifts only.
    logic [17:0] w_line;
    logic [17:0] w_line_off;
    logic [17:0] w_seg_off;
    logic [17:0] w_col_off;
    logic [17:0] w_addr;

    assign w_line     = {10'd0, r_blk_row, w_row};
    assign w_line_off = (r_seg == 2'd0) ? ((w_line << 8) + (w_line << 6))
                                        : ((w_line << 7) + (w_line << 5));
    assign w_seg_off  = (r_seg == 2'd0) ? 18'd0 :
                        (r_seg == 2'd1) ? U_SEG_OFFSET : V_SEG_OFFSET;
    assign w_col_off  = {9'd0, r_blk_col, w_col};
    assign w_addr     = PRE_IDCT_BASE + w_seg_off + w_line_off + w_col_off;

    // Dequantize: widen to 21 bits so a 5-bit shift cannot overflow, then clamp.
    logic [3:0]         w_d;
    logic [2:0]         w_shamt;
    logic signed [20:0] w_ext;
    logic signed [20:0] w_shifted;
    logic [15:0]        w_data;

    assign w_d       = {1'b0, w_row} + {1'b0, w_col};
    assign w_shamt   = shift_amt(r_qsel, w_d);
    assign w_ext     = {{5{coef_data[15]}}, coef_data};
    assign w_shifted = w_ext <<< w_shamt;

    always_comb begin
        w_data = w_shifted[15:0];
        if (w_shifted > 21'sd32767)
            w_data = 16'h7FFF;
        else if (w_shifted < -21'sd32768)
            w_data = 16'h8000;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state      <= S_IDLE;
            r_qsel       <= 1'b0;
            r_zz         <= 6'd0;
            r_blk_col    <= 6'd0;
            r_blk_row    <= 5'd0;
            r_seg        <= 2'd0;
            r_addr       <= 18'd0;
            r_data       <= 16'd0;
            r_we_n       <= 1'b1;
            r_block_done <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_we_n       <= 1'b1;
            r_block_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Enable) begin
                        r_qsel    <= q_sel;
                        r_done    <= 1'b0;
                        r_zz      <= 6'd0;
                        r_blk_col <= 6'd0;
                        r_blk_row <= 5'd0;
                        r_seg     <= 2'd0;
                        r_state   <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (w_xfer) begin
                        r_we_n <= 1'b0;
                        r_addr <= w_addr;
                        r_data <= w_data;
                        r_zz   <= r_zz + 6'd1;
                        if (r_zz == 6'd63) begin
                            r_block_done <= 1'b1;
                            if (w_last_blk) begin
                                r_state <= S_DRAIN;
                            end else if (w_col_wrap) begin
                                r_blk_col <= 6'd0;
                                if (w_row_wrap) begin
                                    r_blk_row <= 5'd0;
                                    r_seg     <= r_seg + 2'd1;
                                end else begin
                                    r_blk_row <= r_blk_row + 5'd1;
                                end
                            end else begin
                                r_blk_col <= r_blk_col + 6'd1;
                            end
                        end
                    end
                end
                // The final write is on the bus during this state.
                S_DRAIN: r_state <= S_FINISH;
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign SRAM_address    = r_addr;
    assign SRAM_write_data = r_data;
    assign SRAM_we_n       = r_we_n;
    assign block_done      = r_block_done;
    assign done            = r_done;

endmodule
